flash_access: RTL and testbench
===============================

Name: flash_access

Overview:
- Flash-side access engine for pgmflash, directly downstream of the ZX port decoder.
- The decoder turns port 0xB3 writes into address-byte strobes and port 0xBB accesses into data read/write strobes. This block owns the 19-bit ROM address and the flash bus (romcs_n, memoe_n, memwe_n, mema18..14, a[13:0], d).
- It runs timed read/write cycles with post-increment.
- It keeps a prefetched read byte so ZX reads of 0xBB return data with no wait states.

Parameters:
- T_SETUP, 1, cycles with cs_n low and address/data stable before the strobe.
- T_PULSE, 3, cycles with oe_n (read) or we_n (write) low. Must be >=1.
- T_HOLD, 1, cycles with cs_n low after the strobe deasserts.

Ports:
- clk  in  1  clk_fpga domain clock.
- rst  in  1  Reset: synchronous, active-high.
- init  in  1  Synchronous soft init, 1-cycle pulse (from write of 0x80 to port 0x33). Same effect as rst.
- adr_wr  in  1  1-cycle strobe: wdata is the next address byte.
- dat_wr  in  1  1-cycle strobe: write wdata to flash at current address.
- dat_rd  in  1  1-cycle strobe at the trailing edge of a ZX read of 0xBB: rdata has been consumed.
- wdata  in  8  Byte from ZX bus.
- rdata  out  8  Prefetched byte at the current address.
- busy  out  1  Flash cycle in progress.
- err  out  1  Sticky: a strobe was dropped while busy.
- fl_a  out  19  Flash address: {mema18..14, a[13:0]}.
- fl_d_out  out  8  Flash write data.
- fl_d_oe  out  1  Drive d bus.
- fl_d_in  in  8  Flash read data.
- fl_cs_n, fl_oe_n, fl_we_n  out  1 each  Flash controls.

Behaviour:
- Reset / init values:
  - fl_cs_n=fl_oe_n=fl_we_n=1, fl_d_oe=0, fl_a=0, fl_d_out=0.
  - rdata=8'hFF, busy=0, err=0, address phase=0.
  - init has identical effect. An in-flight cycle is aborted: all controls go inactive in the cycle after rst/init.
- Address load (3-phase counter):
  - phase 0 loads addr[23:16]; only bits [18:16] are kept, [23:19] are discarded.
  - phase 1 loads addr[15:8]; phase 2 loads addr[7:0].
  - Phase advances 0→1→2→0.
  - Completing phase 2 starts a prefetch read at the new address.
- FSM states: IDLE, SETUP, PULSE, HOLD.
  - Each timed state is held for its parameter count, via a down-counter reloaded on entry.
  - Cycle kind, RD or WR, is latched when leaving IDLE.
- Start latency: strobe in cycle N puts SETUP in N+1, with busy=1 and fl_cs_n=0 from N+1.
- Signals held stable for the whole cycle (SETUP through HOLD): fl_a, fl_cs_n=0.
- Read cycle:
  - fl_oe_n=0 only in PULSE.
  - fl_d_in is captured into rdata on the last PULSE cycle.
  - fl_d_oe stays 0.
- Write cycle:
  - fl_d_oe=1 and fl_d_out=latched wdata from SETUP through HOLD.
  - fl_we_n=0 only in PULSE.
  - rdata is not updated.
- After a data-read or write cycle:
  - At the last HOLD cycle, addr increments mod 2^19 (7FFFF→00000).
  - A prefetch read of the new address starts in the next cycle (SETUP) without passing IDLE. busy stays 1.
  - Prefetch reads (phase-2 trigger or chained) do not increment.
- dat_rd sequence:
  - rdata is already valid when dat_rd arrives.
  - addr increments in the cycle after dat_rd.
  - Then one prefetch read runs, taking T_SETUP+T_PULSE+T_HOLD cycles.
  - rdata holds its old value until capture.
- Busy durations with default parameters:
  - Pure read or prefetch: 5 cycles.
  - Write plus chained prefetch: 10 cycles.
  - busy falls the cycle after the final HOLD cycle.
- Strobes while busy:
  - adr_wr, dat_wr or dat_rd arriving while busy=1 is ignored: no phase change, no address change. err is set next cycle.
  - err clears only on rst/init.
- Simultaneous strobes in one cycle while idle:
  - Priority is adr_wr > dat_wr > dat_rd. The losers are dropped and set err.
  - rst/init override everything.
- Pin-level rules:
  - Never assert fl_oe_n=0 and fl_we_n=0 together.
  - Never assert fl_d_oe while fl_oe_n=0.

Test Plan:
- Reset → all controls inactive, rdata=FF, busy=0, err=0, fl_a=0. Hold for 10 cycles, no flash activity.
- adr_wr 0x12, 0x34, 0x56 → fl_a=0x23456. Exactly one read: cs_n low 5 cycles, oe_n low cycles 2–4. Model returns 0xA5 → rdata=0xA5, busy low after 5 cycles.
- Continue: dat_rd → fl_a=0x23457, new prefetch. rdata stays 0xA5 until the last PULSE cycle, then shows the model byte for 0x23457.
- dat_wr wdata=0x3C at 0x23457 → we_n low 3 cycles with d=0x3C, fl_d_oe=1. Then fl_a=0x23458, prefetch read. busy=10 cycles.
- Load 0x07,0xFF,0xFF, then dat_rd → fl_a wraps to 0x00000. Also load 0xFF,0xFF,0xFF → fl_a=0x7FFFF.
- dat_rd during busy → ignored, err=1, address unchanged. Then init mid-PULSE → next cycle cs_n/oe_n/we_n=1, busy=0, err=0, phase=0, rdata=FF.

Source files
------------

// File: rtl/flash_access.sv
// Flash-side access engine: owns the 19-bit ROM address, runs timed read/write
// cycles on the flash bus and keeps a prefetched byte for zero-wait ZX reads.
module flash_access #(
    parameter int T_SETUP = 1,
    parameter int T_PULSE = 3,
    parameter int T_HOLD  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        adr_wr,
    input  logic        dat_wr,
    input  logic        dat_rd,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        err,
    output logic [18:0] fl_a,
    output logic [7:0]  fl_d_out,
    output logic        fl_d_oe,
    input  logic [7:0]  fl_d_in,
    output logic        fl_cs_n,
    output logic        fl_oe_n,
    output logic        fl_we_n
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // Down-counter reload values; each timed state lasts cnt+1 cycles.
    localparam logic [7:0] SETUP_LD = 8'(T_SETUP - 1);
    localparam logic [7:0] PULSE_LD = 8'(T_PULSE - 1);
    localparam logic [7:0] HOLD_LD  = 8'(T_HOLD - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        wr;
    logic [18:0] addr;
    logic [1:0]  phase;
    logic [7:0]  wbyte;

    always_ff @(posedge clk) begin
        if (rst || init) begin
            state <= S_IDLE;
            cnt   <= '0;
            wr    <= 1'b0;
            addr  <= '0;
            phase <= 2'd0;
            wbyte <= '0;
            rdata <= 8'hFF;
            err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (adr_wr) begin
                        case (phase)
                            2'd0: begin
                                addr[18:16] <= wdata[2:0];
                                phase       <= 2'd1;
                            end
                            2'd1: begin
                                addr[15:8] <= wdata;
                                phase      <= 2'd2;
                            end
                            default: begin
                                addr[7:0] <= wdata;
                                phase     <= 2'd0;
                                wr        <= 1'b0;
                                state     <= S_SETUP;
                                cnt       <= SETUP_LD;
                            end
                        endcase
                        if (dat_wr || dat_rd) err <= 1'b1;
                    end else if (dat_wr) begin
                        wbyte <= wdata;
                        wr    <= 1'b1;
                        state <= S_SETUP;
                        cnt   <= SETUP_LD;
                        if (dat_rd) err <= 1'b1;
                    end else if (dat_rd) begin
                        // The prefetched byte was just consumed: step and refill.
                        addr  <= addr + 19'd1;
                        wr    <= 1'b0;
                        state <= S_SETUP;
                        cnt   <= SETUP_LD;
                    end
                end
                S_SETUP: begin
                    if (cnt == 8'd0) begin
                        state <= S_PULSE;
                        cnt   <= PULSE_LD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_PULSE: begin
                    if (cnt == 8'd0) begin
                        if (!wr) rdata <= fl_d_in;
                        state <= S_HOLD;
                        cnt   <= HOLD_LD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    if (cnt == 8'd0) begin
                        if (wr) begin
                            // Write done: chain straight into a prefetch of the next byte.
                            addr  <= addr + 19'd1;
                            wr    <= 1'b0;
                            state <= S_SETUP;
                            cnt   <= SETUP_LD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
            endcase
            if (state != S_IDLE && (adr_wr || dat_wr || dat_rd)) err <= 1'b1;
        end
    end

    assign busy     = (state != S_IDLE);
    assign fl_a     = addr;
    assign fl_cs_n  = (state == S_IDLE);
    assign fl_oe_n  = !(state == S_PULSE && !wr);
    assign fl_we_n  = !(state == S_PULSE && wr);
    assign fl_d_oe  = wr && (state != S_IDLE);
    assign fl_d_out = wbyte;

endmodule

// File: tb/tb_flash_access.sv
// Directed bench for flash_access: stimulus queues expected flash accesses,
// a bus monitor pops and checks each one as its strobe pulse completes.
module tb_flash_access;

    logic        clk = 1'b0;
    logic        rst, init, adr_wr, dat_wr, dat_rd;
    logic [7:0]  wdata, rdata, fl_d_out, fl_d_in;
    logic        busy, err, fl_d_oe, fl_cs_n, fl_oe_n, fl_we_n;
    logic [18:0] fl_a;

    always #5 clk = ~clk;

    flash_access dut (
        .clk(clk), .rst(rst), .init(init), .adr_wr(adr_wr), .dat_wr(dat_wr),
        .dat_rd(dat_rd), .wdata(wdata), .rdata(rdata), .busy(busy), .err(err),
        .fl_a(fl_a), .fl_d_out(fl_d_out), .fl_d_oe(fl_d_oe), .fl_d_in(fl_d_in),
        .fl_cs_n(fl_cs_n), .fl_oe_n(fl_oe_n), .fl_we_n(fl_we_n)
    );

    // Flash model: one special byte, otherwise low address byte xor 5A.
    assign fl_d_in = (fl_a == 19'h23456) ? 8'hA5 : (fl_a[7:0] ^ 8'h5A);

    typedef struct {
        logic        wr;
        logic [18:0] a;
        logic [7:0]  d;
        int          len;
    } acc_t;

    acc_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pin rules every cycle, one queue entry per completed strobe pulse.
    initial begin
        int          run;
        logic [18:0] pa;
        logic [7:0]  pd;
        logic        pw;
        logic        doe_all;
        acc_t        e;
        run = 0;
        forever begin
            @(negedge clk);
            chk("oe_we_overlap", 32'(!fl_oe_n && !fl_we_n), 0);
            chk("doe_during_oe", 32'(fl_d_oe && !fl_oe_n), 0);
            if (!fl_oe_n || !fl_we_n) begin
                if (run == 0) begin
                    pa      = fl_a;
                    pw      = !fl_we_n;
                    pd      = fl_d_out;
                    doe_all = 1'b1;
                end
                doe_all = doe_all & fl_d_oe;
                run++;
            end else if (run > 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_access", 32'(pa), 32'h7FFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("acc_kind", 32'(pw), 32'(e.wr));
                    chk("acc_addr", 32'(pa), 32'(e.a));
                    chk("acc_pulse_len", run, e.len);
                    if (e.wr) begin
                        chk("wr_data", 32'(pd), 32'(e.d));
                        chk("wr_d_oe", 32'(doe_all), 1);
                    end else begin
                        chk("rd_rdata", 32'(rdata), 32'(e.d));
                    end
                end
                run = 0;
            end
        end
    end

    // Called at a negedge; strobes are sampled by the following posedge.
    task automatic pulse(input logic a, input logic w, input logic r, input logic [7:0] b);
        adr_wr = a; dat_wr = w; dat_rd = r; wdata = b;
        @(negedge clk);
        adr_wr = 1'b0; dat_wr = 1'b0; dat_rd = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int exp_n);
        int n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, exp_n);
    endtask

    initial begin
        rst = 1'b1; init = 1'b0; adr_wr = 1'b0; dat_wr = 1'b0; dat_rd = 1'b0; wdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_cs_n", 32'(fl_cs_n), 1);
        chk("rst_oe_n", 32'(fl_oe_n), 1);
        chk("rst_we_n", 32'(fl_we_n), 1);
        chk("rst_d_oe", 32'(fl_d_oe), 0);
        chk("rst_fl_a", 32'(fl_a), 0);
        chk("rst_d_out", 32'(fl_d_out), 0);
        chk("rst_rdata", 32'(rdata), 32'hFF);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        repeat (10) begin
            @(negedge clk);
            chk("idle_quiet", 32'({busy, fl_cs_n}), 32'b01);
        end

        // Address load, top bits above 18 discarded, then one prefetch.
        pulse(1, 0, 0, 8'h12);
        chk("phase0_load", 32'(fl_a), 32'h20000);
        chk("phase0_no_busy", 32'(busy), 0);
        pulse(1, 0, 0, 8'h34);
        exp_q.push_back('{1'b0, 19'h23456, 8'hA5, 3});
        pulse(1, 0, 0, 8'h56);
        chk("addr_loaded", 32'(fl_a), 32'h23456);
        chk("setup_cs_n", 32'(fl_cs_n), 0);
        chk("setup_oe_n", 32'(fl_oe_n), 1);
        wait_idle("busy_prefetch", 5);
        chk("prefetch_rdata", 32'(rdata), 32'hA5);

        // dat_rd: step address, old byte held until capture.
        exp_q.push_back('{1'b0, 19'h23457, 8'h0D, 3});
        pulse(0, 0, 1, 8'h00);
        chk("datrd_addr", 32'(fl_a), 32'h23457);
        chk("datrd_hold_setup", 32'(rdata), 32'hA5);
        @(negedge clk);
        chk("datrd_hold_pulse", 32'(rdata), 32'hA5);
        wait_idle("busy_datrd", 4);
        chk("datrd_rdata", 32'(rdata), 32'h0D);

        // Write with chained prefetch.
        exp_q.push_back('{1'b1, 19'h23457, 8'h3C, 3});
        exp_q.push_back('{1'b0, 19'h23458, 8'h02, 3});
        pulse(0, 1, 0, 8'h3C);
        chk("wr_setup_d_oe", 32'(fl_d_oe), 1);
        chk("wr_setup_d_out", 32'(fl_d_out), 32'h3C);
        chk("wr_setup_we_n", 32'(fl_we_n), 1);
        wait_idle("busy_write", 10);
        chk("wr_next_addr", 32'(fl_a), 32'h23458);
        chk("wr_rdata", 32'(rdata), 32'h02);
        chk("wr_no_err", 32'(err), 0);

        // Wrap 7FFFF -> 00000.
        exp_q.push_back('{1'b0, 19'h7FFFF, 8'hA5, 3});
        pulse(1, 0, 0, 8'h07); pulse(1, 0, 0, 8'hFF); pulse(1, 0, 0, 8'hFF);
        wait_idle("busy_top", 5);
        chk("top_addr", 32'(fl_a), 32'h7FFFF);
        exp_q.push_back('{1'b0, 19'h00000, 8'h5A, 3});
        pulse(0, 0, 1, 8'h00);
        chk("wrap_addr", 32'(fl_a), 0);
        wait_idle("busy_wrap", 5);
        chk("wrap_rdata", 32'(rdata), 32'h5A);

        exp_q.push_back('{1'b0, 19'h7FFFF, 8'hA5, 3});
        pulse(1, 0, 0, 8'hFF); pulse(1, 0, 0, 8'hFF); pulse(1, 0, 0, 8'hFF);
        wait_idle("busy_ff", 5);
        chk("ff_discard_addr", 32'(fl_a), 32'h7FFFF);

        // Strobe while busy is dropped; init mid-PULSE aborts the read.
        exp_q.push_back('{1'b0, 19'h00000, 8'hFF, 1});
        pulse(0, 0, 1, 8'h00);
        pulse(0, 0, 1, 8'h00);
        chk("busy_drop_err", 32'(err), 1);
        chk("busy_drop_addr", 32'(fl_a), 0);
        chk("busy_drop_in_pulse", 32'(fl_oe_n), 0);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        chk("init_cs_n", 32'(fl_cs_n), 1);
        chk("init_oe_n", 32'(fl_oe_n), 1);
        chk("init_we_n", 32'(fl_we_n), 1);
        chk("init_busy", 32'(busy), 0);
        chk("init_err", 32'(err), 0);
        chk("init_rdata", 32'(rdata), 32'hFF);

        // Simultaneous adr_wr + dat_rd while idle: address wins, phase restarted at 0.
        exp_q.push_back('{1'b0, 19'h10203, 8'h59, 3});
        pulse(1, 0, 1, 8'h01);
        chk("simul_err", 32'(err), 1);
        chk("simul_addr", 32'(fl_a), 32'h10000);
        chk("simul_busy", 32'(busy), 0);
        pulse(1, 0, 0, 8'h02);
        pulse(1, 0, 0, 8'h03);
        wait_idle("busy_after_init", 5);
        chk("after_init_rdata", 32'(rdata), 32'h59);

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
